// File: rtl/multimult_dot_sched_if.sv
// Stream bundle for multimult_dot_sched: operand-pair input and dot-product
// result output. The slave modport is the scheduler's view, master is the
// requester/consumer's view.
interface multimult_dot_sched_if #(
  parameter int ACC_W = 32
) ();

  logic             s_valid;
  logic             s_ready;
  logic [4:0]       s_a;
  logic [4:0]       s_b;
  logic             s_last;

  logic             m_valid;
  logic             m_ready;
  logic [ACC_W-1:0] m_data;

  modport slave (
    input  s_valid, s_a, s_b, s_last, m_ready,
    output s_ready, m_valid, m_data
  );

  modport master (
    output s_valid, s_a, s_b, s_last, m_ready,
    input  s_ready, m_valid, m_data
  );

endinterface

// File: rtl/multimult_dot_sched.sv
// multimult_dot_sched: packs up to 12 signed operand pairs into the 54-bit
// A/B vectors of a MULT54X54 multi-multiplier (even lanes 5-bit, odd lanes
// 4-bit), issues them, folds the four group sums into an accumulator and
// emits one signed dot product per s_last-terminated vector.
// Optional feature: define MULTIMULT_SCHED_STATS_EN to add the 16-bit
// batch_cnt output counting issued batches.
module multimult_dot_sched #(
  parameter int MULT_LAT = 1,
  parameter int ACC_W    = 32
) (
  input  logic                         CLK,
  input  logic                         RST,
  multimult_dot_sched_if.slave         bus,
  output logic [53:0]                  MA,
  output logic [53:0]                  MB,
  input  logic [44:0]                  MY,
`ifdef MULTIMULT_SCHED_STATS_EN
  output logic [15:0]                  batch_cnt,
`endif
  output logic                         ovf_err
);

  typedef enum logic [2:0] {
    FILL,
    ISSUE,
    WAIT,
    ACCUM,
    OUT
  } state_t;

  localparam int          CW        = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = (MULT_LAT == 0) ? '0 : CW'(MULT_LAT - 1);

  state_t           state;
  state_t           state_next;

  logic [3:0]       idx;
  logic [53:0]      pack_a;
  logic [53:0]      pack_b;
  logic [53:0]      fill_a;
  logic [53:0]      fill_b;
  logic             lane_ovf;
  logic             batch_last;
  logic [CW-1:0]    wait_cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] m_data_q;
  logic             s_ready_q;
  logic             m_valid_q;
  logic             accept;
  logic             issue_go;

  assign bus.s_ready = s_ready_q;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;

  // s_ready_q mirrors (state == FILL), so acceptance never depends on s_valid
  // feeding back into s_ready.
  assign accept   = s_ready_q && bus.s_valid;
  assign issue_go = accept && ((idx == 4'd11) || bus.s_last);

  // Lane write: the current pair merged into lane idx. Odd lanes keep only
  // the low four bits, so anything outside -8..7 is flagged as overflow.
  always_comb begin
    fill_a   = pack_a;
    fill_b   = pack_b;
    lane_ovf = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (idx == 4'(k)) begin
        if ((k % 2) == 0) begin
          fill_a[9*(k/2) +: 5] = bus.s_a;
          fill_b[9*(k/2) +: 5] = bus.s_b;
        end else begin
          fill_a[9*(k/2)+5 +: 4] = bus.s_a[3:0];
          fill_b[9*(k/2)+5 +: 4] = bus.s_b[3:0];
          lane_ovf = (bus.s_a[4] != bus.s_a[3]) || (bus.s_b[4] != bus.s_b[3]);
        end
      end
    end
  end

  // Fold the four sign-extended group sums into the running accumulator;
  // overflow simply wraps at ACC_W bits.
  always_comb begin
    acc_sum = acc
            + {{(ACC_W-12){MY[11]}}, MY[11:0]}
            + {{(ACC_W-12){MY[23]}}, MY[23:12]}
            + {{(ACC_W-12){MY[35]}}, MY[35:24]}
            + {{(ACC_W-9){MY[44]}},  MY[44:36]};
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode for the fill / issue / wait / accumulate / output loop.
  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (issue_go) state_next = ISSUE;
      ISSUE:   state_next = (MULT_LAT == 0) ? ACCUM : WAIT;
      WAIT:    if (wait_cnt == WAIT_LAST) state_next = ACCUM;
      ACCUM:   state_next = batch_last ? OUT : FILL;
      OUT:     if (bus.m_ready) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  // Datapath: lane packing, multiplier operand registers, latency counter,
  // accumulator, result register and registered handshake flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      idx        <= '0;
      pack_a     <= '0;
      pack_b     <= '0;
      MA         <= '0;
      MB         <= '0;
      batch_last <= 1'b0;
      wait_cnt   <= '0;
      acc        <= '0;
      m_data_q   <= '0;
      s_ready_q  <= 1'b1;
      m_valid_q  <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      s_ready_q <= (state_next == FILL);
      m_valid_q <= (state_next == OUT);
      case (state)
        FILL: begin
          if (accept) begin
            pack_a <= fill_a;
            pack_b <= fill_b;
            if (lane_ovf) ovf_err <= 1'b1;
            if (issue_go) begin
              idx        <= '0;
              batch_last <= bus.s_last;
              MA         <= fill_a;
              MB         <= fill_b;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + CW'(1);
        end
        ACCUM: begin
          if (batch_last) begin
            m_data_q <= acc_sum;
            acc      <= '0;
          end else begin
            acc    <= acc_sum;
            pack_a <= '0;
            pack_b <= '0;
            MA     <= '0;
            MB     <= '0;
          end
        end
        OUT: begin
          if (bus.m_ready) begin
            batch_last <= 1'b0;
            pack_a     <= '0;
            pack_b     <= '0;
            MA         <= '0;
            MB         <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MULTIMULT_SCHED_STATS_EN
  // Batch counter: one tick per ISSUE, free-running wrap at 16 bits.
  always_ff @(posedge CLK) begin
    if (RST) begin
      batch_cnt <= '0;
    end else if (state == ISSUE) begin
      batch_cnt <= batch_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multimult_dot_sched.sv
// Directed self-checking bench for multimult_dot_sched with MULT_LAT=1.
// A behavioural MULT54X54 model registers the four group sums one cycle
// after the operands, standing in for the techmapped multiplier.
module tb_multimult_dot_sched;

  localparam int ACC_W = 32;

  logic        clk;
  logic        rst;
  logic [53:0] ma;
  logic [53:0] mb;
  logic [44:0] my;
  logic        ovf_err;
`ifdef MULTIMULT_SCHED_STATS_EN
  logic [15:0] batch_cnt;
`endif

  int checks = 0;
  int errors = 0;

  multimult_dot_sched_if #(.ACC_W(ACC_W)) bus ();

  multimult_dot_sched #(
    .MULT_LAT (1),
    .ACC_W    (ACC_W)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .bus       (bus.slave),
    .MA        (ma),
    .MB        (mb),
    .MY        (my),
`ifdef MULTIMULT_SCHED_STATS_EN
    .batch_cnt (batch_cnt),
`endif
    .ovf_err   (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference multi-multiplier: 12 signed lane products, summed per 3-lane
  // group, packed into 12/12/12/9-bit fields.
  function automatic logic [44:0] multModel(input logic [53:0] a, input logic [53:0] b);
    int sums [4];
    int off;
    int p;
    for (int g = 0; g < 4; g++) sums[g] = 0;
    for (int k = 0; k < 12; k++) begin
      if ((k % 2) == 0) begin
        off = 9 * (k / 2);
        p = $signed(a[off +: 5]) * $signed(b[off +: 5]);
      end else begin
        off = 9 * (k / 2) + 5;
        p = $signed(a[off +: 4]) * $signed(b[off +: 4]);
      end
      sums[k / 3] = sums[k / 3] + p;
    end
    return {sums[3][8:0], sums[2][11:0], sums[1][11:0], sums[0][11:0]};
  endfunction

  // Multiplier latency of one cycle from the operand registers.
  always @(posedge clk) my <= multModel(ma, mb);

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkData(input string tag, input logic signed [ACC_W-1:0] expected);
    checks++;
    assert (bus.m_data === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, $signed(bus.m_data), expected);
    end
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one pair and hold it until accepted; returns at accept edge + 1.
  task automatic applyStimulus(input logic [4:0] a, input logic [4:0] b, input logic last);
    int n;
    n = 0;
    bus.s_valid = 1'b1;
    bus.s_a     = a;
    bus.s_b     = b;
    bus.s_last  = last;
    while (!bus.s_ready && n < 100) begin
      waitCycles(1);
      n++;
    end
    if (!bus.s_ready) checkOutput("s_ready_timeout", {63'd0, bus.s_ready}, 64'd1);
    waitCycles(1);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  // Complete one result transfer with m_ready pulsed for a single cycle.
  task automatic collect();
    bus.m_ready = 1'b1;
    waitCycles(1);
    bus.m_ready = 1'b0;
    checkOutput("m_valid_after_xfer", {63'd0, bus.m_valid}, 64'd0);
    checkOutput("s_ready_after_xfer", {63'd0, bus.s_ready}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_a     = '0;
    bus.s_b     = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    waitCycles(3);
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_s_ready", {63'd0, bus.s_ready}, 64'd1);
    checkOutput("rst_m_valid", {63'd0, bus.m_valid}, 64'd0);
    checkOutput("rst_ma", {10'd0, ma}, 64'd0);
    checkOutput("rst_mb", {10'd0, mb}, 64'd0);
    checkOutput("rst_m_data", {32'd0, bus.m_data}, 64'd0);
    checkOutput("rst_ovf", {63'd0, ovf_err}, 64'd0);

    // 3*4 + (-2)*5 + 7*(-1) = -5
    $display("[TB] three-pair vector");
    applyStimulus(5'sd3, 5'sd4, 1'b0);
    applyStimulus(-5'sd2, 5'sd5, 1'b0);
    applyStimulus(5'sd7, -5'sd1, 1'b1);
    checkOutput("v1_ma", {10'd0, ma}, 64'h0FC3);
    checkOutput("v1_mb", {10'd0, mb}, 64'h3EA4);
    checkOutput("v1_s_ready_issue", {63'd0, bus.s_ready}, 64'd0);
    waitCycles(2);
    checkOutput("v1_m_valid_early", {63'd0, bus.m_valid}, 64'd0);
    checkOutput("v1_ma_stable", {10'd0, ma}, 64'h0FC3);
    waitCycles(1);
    checkOutput("v1_m_valid", {63'd0, bus.m_valid}, 64'd1);
    checkData("v1_m_data", -32'sd5);
    checkOutput("v1_ovf", {63'd0, ovf_err}, 64'd0);
    collect();
    checkOutput("v1_ma_cleared", {10'd0, ma}, 64'd0);

    // 13 x (1*1): a full batch of 12 then a single-lane batch.
    $display("[TB] thirteen-pair vector");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(5'd1, 5'd1, (i == 12));
      if (i == 11) begin
        checkOutput("v2_ma_full", {10'd0, ma}, {10'd0, {6{9'h021}}});
        checkOutput("v2_m_valid_mid", {63'd0, bus.m_valid}, 64'd0);
      end
    end
    checkOutput("v2_ma_lane0", {10'd0, ma}, 64'd1);
    checkOutput("v2_mb_lane0", {10'd0, mb}, 64'd1);
    waitCycles(3);
    checkOutput("v2_m_valid", {63'd0, bus.m_valid}, 64'd1);
    checkData("v2_m_data", 32'sd13);

    // Overflow on lane 1: a=8 truncates to -8; result held under backpressure.
    $display("[TB] odd-lane overflow with backpressure");
    collect();
    applyStimulus(5'd0, 5'd0, 1'b0);
    applyStimulus(5'd8, 5'd1, 1'b1);
    checkOutput("v3_ma", {10'd0, ma}, 64'h100);
    checkOutput("v3_ovf", {63'd0, ovf_err}, 64'd1);
    waitCycles(3);
    checkOutput("v3_m_valid", {63'd0, bus.m_valid}, 64'd1);
    checkData("v3_m_data", -32'sd8);
    for (int i = 0; i < 5; i++) begin
      waitCycles(1);
      checkData("v3_hold_data", -32'sd8);
      checkOutput("v3_hold_valid", {63'd0, bus.m_valid}, 64'd1);
      checkOutput("v3_hold_s_ready", {63'd0, bus.s_ready}, 64'd0);
    end
    collect();
    checkOutput("v3_ovf_sticky", {63'd0, ovf_err}, 64'd1);

    // Reset during WAIT discards the partial vector.
    $display("[TB] reset in WAIT");
    for (int i = 0; i < 5; i++) applyStimulus(5'd1, 5'd1, (i == 4));
    waitCycles(1);
    rst = 1'b1;
    waitCycles(1);
    rst = 1'b0;
    checkOutput("rw_m_valid", {63'd0, bus.m_valid}, 64'd0);
    checkOutput("rw_ma", {10'd0, ma}, 64'd0);
    checkOutput("rw_s_ready", {63'd0, bus.s_ready}, 64'd1);
    checkOutput("rw_ovf", {63'd0, ovf_err}, 64'd0);
    applyStimulus(5'd2, 5'd3, 1'b1);
    waitCycles(3);
    checkOutput("rw_m_valid_after", {63'd0, bus.m_valid}, 64'd1);
    checkData("rw_m_data", 32'sd6);
    collect();

    // Three 12-pair vectors of (1,2), each ending exactly on lane 11.
    $display("[TB] three full-batch vectors");
    rst = 1'b1;
    waitCycles(1);
    rst = 1'b0;
`ifdef MULTIMULT_SCHED_STATS_EN
    checkOutput("stats_rst", {48'd0, batch_cnt}, 64'd0);
`endif
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < 12; i++) applyStimulus(5'd1, 5'd2, (i == 11));
      waitCycles(3);
      checkOutput("full_m_valid", {63'd0, bus.m_valid}, 64'd1);
      checkData("full_m_data", 32'sd24);
      collect();
    end
`ifdef MULTIMULT_SCHED_STATS_EN
    checkOutput("stats_batch_cnt", {48'd0, batch_cnt}, 64'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
